// File: rtl/snd_mix.sv
// Expansion-audio mixer: snapshots all channels on each M2 fall and does a serial gain MAC with one multiplier.
// Then it saturates the sum and registers it for the DAC. Define SND_MIX_LPF_EN to add a one-pole output low-pass stage.
module snd_mix #(
   parameter int CH_NUM = 4,
   parameter int SMP_W  = 12,
   parameter int GAIN_W = 8,
   parameter int OUT_W  = 16
`ifdef SND_MIX_LPF_EN
  ,parameter int LPF_SHIFT = 3
`endif
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     m2,
   input  logic [CH_NUM*SMP_W-1:0]  ch_smp,
   input  logic [CH_NUM*GAIN_W-1:0] ch_gain,
   input  logic [CH_NUM-1:0]        ch_en,
   input  logic                     mute,
   input  logic                     clip_clr,
   output logic [OUT_W-1:0]         snd,
   output logic                     smp_stb,
   output logic                     clip
);

   localparam int ACC_W  = SMP_W + GAIN_W + $clog2(CH_NUM);
   localparam int PROD_W = SMP_W + GAIN_W;
   localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int SH     = GAIN_W - 1 - (OUT_W - SMP_W);
   localparam int SHR    = (SH > 0) ? SH : 0;
   localparam int SHL    = (SH < 0) ? -SH : 0;
   localparam int SC_W   = ACC_W + SHL;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

`ifdef SND_MIX_LPF_EN
   typedef enum logic [1:0] {IDLE, MAC, SAT, LPF} state_t;
   localparam int Y_W = OUT_W + LPF_SHIFT;
`else
   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
`endif

   state_t state, state_nxt;

   logic m2_s1, m2_s2, m2_s3, fall_det;

   logic [CH_NUM*SMP_W-1:0]  sh_smp;
   logic [CH_NUM*GAIN_W-1:0] sh_gain;
   logic [CH_NUM-1:0]        sh_en;
   logic                     sh_mute;

   logic [ACC_W-1:0]  acc;
   logic [IDX_W-1:0]  idx;
   logic [SMP_W-1:0]  cur_smp;
   logic [GAIN_W-1:0] cur_gain;
   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  mac_term;
   logic [SC_W-1:0]   scaled;
   logic              sat_ovf;
   logic [OUT_W-1:0]  sat_res;
   logic              clip_set;

`ifdef SND_MIX_LPF_EN
   logic [OUT_W-1:0]      x_q;
   logic [Y_W-1:0]        y;
   logic signed [Y_W:0]   lpf_diff;
   logic [Y_W-1:0]        y_nxt;
`endif

   // m2 is asynchronous: two flops to settle it, a third to remember the previous level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_s1    <= 1'b0;
         m2_s2    <= 1'b0;
         m2_s3    <= 1'b0;
         fall_det <= 1'b0;
      end else begin
         m2_s1    <= m2;
         m2_s2    <= m2_s1;
         m2_s3    <= m2_s2;
         fall_det <= m2_s3 & ~m2_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fall_det) state_nxt = MAC;
         MAC:     if (idx == LAST_IDX) state_nxt = SAT;
`ifdef SND_MIX_LPF_EN
         SAT:     state_nxt = LPF;
         LPF:     state_nxt = IDLE;
`else
         SAT:     state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cur_smp  = sh_smp[idx*SMP_W +: SMP_W];
      cur_gain = sh_gain[idx*GAIN_W +: GAIN_W];
      prod     = PROD_W'(cur_smp) * PROD_W'(cur_gain);
      mac_term = sh_en[idx] ? ACC_W'(prod) : '0;
      scaled   = (SC_W'(acc) >> SHR) << SHL;
      sat_ovf  = |scaled[SC_W-1:OUT_W];
      sat_res  = sh_mute ? '0 : (sat_ovf ? '1 : scaled[OUT_W-1:0]);
      clip_set = (state == SAT) && sat_ovf && !sh_mute;
   end

`ifdef SND_MIX_LPF_EN
   // y carries LPF_SHIFT fractional bits; the step toward x<<LPF_SHIFT is floor-divided
   always_comb begin
      lpf_diff = $signed({1'b0, x_q, {LPF_SHIFT{1'b0}}}) - $signed({1'b0, y});
      y_nxt    = Y_W'($signed({1'b0, y}) + (lpf_diff >>> LPF_SHIFT));
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_smp  <= '0;
         sh_gain <= '0;
         sh_en   <= '0;
         sh_mute <= 1'b0;
         acc     <= '0;
         idx     <= '0;
         snd     <= '0;
         smp_stb <= 1'b0;
         clip    <= 1'b0;
`ifdef SND_MIX_LPF_EN
         x_q     <= '0;
         y       <= '0;
`endif
      end else begin
         smp_stb <= 1'b0;
         if (clip_set)      clip <= 1'b1;
         else if (clip_clr) clip <= 1'b0;
         case (state)
            IDLE: begin
               if (fall_det) begin
                  sh_smp  <= ch_smp;
                  sh_gain <= ch_gain;
                  sh_en   <= ch_en;
                  sh_mute <= mute;
                  acc     <= '0;
                  idx     <= '0;
               end
            end
            MAC: begin
               acc <= acc + mac_term;
               idx <= idx + IDX_W'(1);
            end
`ifdef SND_MIX_LPF_EN
            SAT: x_q <= sat_res;
            LPF: begin
               if (sh_mute) begin
                  y   <= '0;
                  snd <= '0;
               end else begin
                  y   <= y_nxt;
                  snd <= y_nxt[Y_W-1:LPF_SHIFT];
               end
               smp_stb <= 1'b1;
            end
`else
            SAT: begin
               snd     <= sat_res;
               smp_stb <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snd_mix.sv
// Self-checking bench for snd_mix: fixed vector table, hand-written corner sequences and randomized runs against an arithmetic model.
// The LPF build (SND_MIX_LPF_EN) adds a one-pole filter to the model and a step-response sequence.
module tb_snd_mix;

   localparam int CH_NUM = 4;
   localparam int SMP_W  = 12;
   localparam int GAIN_W = 8;
   localparam int OUT_W  = 16;
   localparam int SH     = GAIN_W - 1 - (OUT_W - SMP_W);
`ifdef SND_MIX_LPF_EN
   localparam int LAT = 10;
`else
   localparam int LAT = 9;
`endif

   logic                     clk;
   logic                     rst_n;
   logic                     m2;
   logic [CH_NUM*SMP_W-1:0]  ch_smp;
   logic [CH_NUM*GAIN_W-1:0] ch_gain;
   logic [CH_NUM-1:0]        ch_en;
   logic                     mute;
   logic                     clip_clr;
   logic [OUT_W-1:0]         snd;
   logic                     smp_stb;
   logic                     clip;

   snd_mix dut (
      .clk(clk), .rst_n(rst_n), .m2(m2),
      .ch_smp(ch_smp), .ch_gain(ch_gain), .ch_en(ch_en),
      .mute(mute), .clip_clr(clip_clr),
      .snd(snd), .smp_stb(smp_stb), .clip(clip)
   );

   typedef struct {
      logic [3:0][11:0] smp;
      logic [3:0][7:0]  gain;
      logic [3:0]       en;
      logic             mu;
      int               exp_snd;
      logic             exp_clip;
   } vec_t;

   vec_t    vecs[5];
   int      pass_cnt;
   int      check_cnt;
   longint  m_y;
   bit      m_clip;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int satRef(input logic [3:0][11:0] s, input logic [3:0][7:0] g,
                                 input logic [3:0] en, input logic mu, output bit ovf);
      longint sum = 0;
      longint sc;
      for (int i = 0; i < CH_NUM; i++)
         if (en[i]) sum += longint'(s[i]) * longint'(g[i]);
      if (SH >= 0) sc = sum >> SH;
      else         sc = sum << (-SH);
      ovf = 1'b0;
      if (mu) return 0;
      if (sc > 65535) begin
         ovf = 1'b1;
         return 65535;
      end
      return int'(sc);
   endfunction

   function automatic int lpfRef(input int x, input logic mu);
`ifdef SND_MIX_LPF_EN
      if (mu) m_y = 0;
      else    m_y = m_y + (((longint'(x) <<< 3) - m_y) >>> 3);
      return int'(m_y >>> 3);
`else
      return mu ? 0 : x;
`endif
   endfunction

   task automatic applyStimulus(input logic [3:0][11:0] s, input logic [3:0][7:0] g,
                                input logic [3:0] en, input logic mu);
      ch_smp  = s;
      ch_gain = g;
      ch_en   = en;
      mute    = mu;
   endtask

   task automatic checkOutput(input string name, input longint act, input longint exp);
      check_cnt++;
      if (act == exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Drives one M2 low period; edge numbers count clk rises after m2 falls
   task automatic runSample(input int clr_edge, input int glitch_edge, input bit pulse,
                            output int lat, output int stbs, output int s);
      lat  = -1;
      stbs = 0;
      s    = -1;
      m2   = 1'b0;
      clip_clr = (clr_edge == 1);
      for (int e = 1; e <= 24; e++) begin
         @(posedge clk);
         #1;
         if (smp_stb) begin
            stbs++;
            if (lat < 0) begin
               lat = e;
               s   = int'(snd);
            end
         end
         clip_clr = (e + 1 == clr_edge);
         if (e == glitch_edge) ch_smp = '1;
         if (pulse && e == 3) m2 = 1'b1;
         if (pulse && e == 4) m2 = 1'b0;
      end
      m2       = 1'b1;
      clip_clr = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic doRun(input string name, input int exp_snd, input bit exp_clip,
                        input int clr_edge, input int glitch_edge, input bit pulse);
      int lat, stbs, s;
      runSample(clr_edge, glitch_edge, pulse, lat, stbs, s);
      checkOutput({name, " snd"}, s, exp_snd);
      checkOutput({name, " latency"}, lat, LAT);
      checkOutput({name, " stb count"}, stbs, 1);
      checkOutput({name, " clip"}, clip, exp_clip);
      checkOutput({name, " hold"}, snd, exp_snd);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      m2    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_y    = 0;
      m_clip = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic pulseClear();
      clip_clr = 1'b1;
      @(posedge clk);
      #1;
      clip_clr = 1'b0;
      m_clip   = 1'b0;
   endtask

   initial begin
      logic [3:0][11:0] rs;
      logic [3:0][7:0]  rg;
      logic [3:0]       ren;
      logic             rmu;
      bit               ovf;
      int               x;

      pass_cnt  = 0;
      check_cnt = 0;
      m_y       = 0;
      m_clip    = 1'b0;

      vecs[0] = '{smp: {12'd0, 12'd0, 12'd0, 12'd4095}, gain: {8'd0, 8'd0, 8'd0, 8'd128},
                  en: 4'b0001, mu: 1'b0, exp_snd: 65520, exp_clip: 1'b0};
      vecs[1] = '{smp: {12'd0, 12'd0, 12'd1000, 12'd0}, gain: {8'd0, 8'd0, 8'd64, 8'd0},
                  en: 4'b0010, mu: 1'b0, exp_snd: 8000, exp_clip: 1'b0};
      vecs[2] = '{smp: {12'd0, 12'd0, 12'd1000, 12'd0}, gain: {8'd0, 8'd0, 8'd64, 8'd0},
                  en: 4'b0000, mu: 1'b0, exp_snd: 0, exp_clip: 1'b0};
      vecs[3] = '{smp: {4{12'd4095}}, gain: {4{8'd255}},
                  en: 4'b1111, mu: 1'b0, exp_snd: 65535, exp_clip: 1'b1};
      vecs[4] = '{smp: {12'd0, 12'd0, 12'd1000, 12'd0}, gain: {8'd0, 8'd0, 8'd64, 8'd0},
                  en: 4'b0010, mu: 1'b1, exp_snd: 0, exp_clip: 1'b1};

      rst_n    = 1'b0;
      m2       = 1'b1;
      ch_smp   = '0;
      ch_gain  = '0;
      ch_en    = '0;
      mute     = 1'b0;
      clip_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset snd", snd, 0);
      checkOutput("reset stb", smp_stb, 0);
      checkOutput("reset clip", clip, 0);
      doReset();

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].smp, vecs[i].gain, vecs[i].en, vecs[i].mu);
         doRun($sformatf("vec%0d", i), lpfRef(vecs[i].exp_snd, vecs[i].mu), vecs[i].exp_clip, 0, 0, 1'b0);
      end

      pulseClear();
      checkOutput("clip_clr alone", clip, 0);
      applyStimulus(vecs[3].smp, vecs[3].gain, vecs[3].en, 1'b0);
      doRun("clr vs sat", lpfRef(65535, 1'b0), 1'b1, 9, 0, 1'b0);
      m_clip = 1'b1;

      applyStimulus(vecs[1].smp, vecs[1].gain, vecs[1].en, 1'b0);
      doRun("snapshot", lpfRef(8000, 1'b0), 1'b1, 0, 5, 1'b0);
      applyStimulus(vecs[1].smp, vecs[1].gain, vecs[1].en, 1'b0);
      doRun("drop fall", lpfRef(8000, 1'b0), 1'b1, 0, 0, 1'b1);

      // abort at T+2: fall_det is seen after edge 3, so reset lands after edge 5
      applyStimulus(vecs[0].smp, vecs[0].gain, vecs[0].en, 1'b0);
      m2 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort snd", snd, 0);
      checkOutput("abort stb", smp_stb, 0);
      checkOutput("abort clip", clip, 0);
      doReset();
      doRun("after abort", lpfRef(65520, 1'b0), 1'b0, 0, 0, 1'b0);

      for (int n = 0; n < 20; n++) begin
         for (int c = 0; c < CH_NUM; c++) begin
            rs[c] = 12'($urandom_range(0, 4095));
            rg[c] = 8'($urandom_range(0, 255));
         end
         ren = 4'($urandom_range(0, 15));
         rmu = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) pulseClear();
         applyStimulus(rs, rg, ren, rmu);
         x = satRef(rs, rg, ren, rmu, ovf);
         m_clip = m_clip | ovf;
         doRun($sformatf("rand%0d", n), lpfRef(x, rmu), m_clip, 0, 0, 1'b0);
      end

`ifdef SND_MIX_LPF_EN
      begin
         int lat, stbs, s, prev, bad;
         doReset();
         applyStimulus(vecs[0].smp, vecs[0].gain, vecs[0].en, 1'b0);
         prev = 0;
         bad  = 0;
         for (int k = 0; k < 100; k++) begin
            runSample(0, 0, 1'b0, lat, stbs, s);
            if (k == 0) begin
               checkOutput("lpf first", s, 8190);
               checkOutput("lpf latency", lat, 10);
            end
            if (s < prev) bad++;
            prev = s;
         end
         checkOutput("lpf monotonic violations", bad, 0);
         checkOutput("lpf converged", ((65520 - prev) <= 8 && prev <= 65520) ? 1 : 0, 1);
      end
`endif

      $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
